// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      PLL_RESET   = 2'd0,
      WAIT_LOCK   = 2'd1,
      STABLE_WAIT = 2'd2,
      RUN         = 2'd3
   } sup_state_t;

   localparam int SUP_STATE_W = 2;
   localparam int RETRY_W     = 8;
   localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

   // Used to size the shared timer to the longest interval it has to count.
   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the local clock domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, releases
// the core reset, and restarts the PLL on lock loss, timeout or request.
//
// state       | meaning
// PLL_RESET   | pll_rst held for PLL_RST_CYCLES
// WAIT_LOCK   | waiting for locked_s, bounded by RELOCK_TIMEOUT
// STABLE_WAIT | locked_s must stay high for LOCK_STABLE_CYCLES
// RUN         | core released, watching for lock loss
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RELOCK_TIMEOUT     = 65536
) (
   input  logic                   refclk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   input  logic                   force_relock,
   output logic                   pll_rst,
   output logic                   core_rst_n,
   output logic                   lock_lost,
   output logic [RETRY_W-1:0]     retry_count,
   output logic [SUP_STATE_W-1:0] sup_state
);

   localparam int CNT_MAX = max_of3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RELOCK_TIMEOUT);
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] RST_TC = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(RELOCK_TIMEOUT - 1);

   sup_state_t         state_q;
   sup_state_t         state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_d;
   logic               retry_inc;
   logic               drop_run;
   logic               restart;
   logic               locked_s;
   logic               pll_rst_d;
   logic               core_rst_n_d;
   logic               lock_lost_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk_sys (refclk),
      .rst_b   (rst_n),
      .d       (pll_locked),
      .q       (locked_s)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PLL_RESET;
         cnt_q      <= '0;
         retry_q    <= '0;
         pll_rst    <= 1'b1;
         core_rst_n <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         pll_rst    <= pll_rst_d;
         core_rst_n <= core_rst_n_d;
         lock_lost  <= lock_lost_d;
      end
   end

   // A relock request outranks everything, including a lock drop in RUN.
   assign restart = force_relock && (state_q != PLL_RESET);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_inc = 1'b0;
      drop_run  = 1'b0;
      if (restart) begin
         state_d   = PLL_RESET;
         cnt_d     = '0;
         retry_inc = 1'b1;
      end else begin
         case (state_q)
            PLL_RESET: begin
               if (cnt_q == RST_TC) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = STABLE_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q == TMO_TC) begin
                  state_d   = PLL_RESET;
                  cnt_d     = '0;
                  retry_inc = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STABLE_WAIT: begin
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STB_TC) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_d   = PLL_RESET;
                  cnt_d     = '0;
                  retry_inc = 1'b1;
                  drop_run  = 1'b1;
               end
            end
            default: begin
               state_d = PLL_RESET;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // pll_rst tracks the state it is entering; core_rst_n lags RUN by one cycle.
   always_comb begin
      pll_rst_d    = (state_d == PLL_RESET);
      core_rst_n_d = (state_q == RUN);
      lock_lost_d  = drop_run;
      retry_d      = retry_q;
      if (retry_inc && (retry_q != RETRY_MAX)) begin
         retry_d = retry_q + 1'b1;
      end
   end

   assign retry_count = retry_q;
   assign sup_state   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with short timer parameters.
module tb_pll_lock_supervisor;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       force_relock;
   logic       pll_rst;
   logic       core_rst_n;
   logic       lock_lost;
   logic [7:0] retry_count;
   logic [1:0] sup_state;

   int checks    = 0;
   int failures  = 0;
   int ll_pulses = 0;

   typedef struct {
      logic       locked;
      logic       frc;
      int         n;
      logic [1:0] st;
      logic       prst;
      logic       core;
      logic       ll;
      int         retry;
   } vec_t;

   typedef struct {
      logic [1:0] st;
      logic       prst;
      logic       core;
      logic       ll;
      int         retry;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   always #5 refclk = ~refclk;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES (8),
      .RELOCK_TIMEOUT     (32)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .force_relock (force_relock),
      .pll_rst      (pll_rst),
      .core_rst_n   (core_rst_n),
      .lock_lost    (lock_lost),
      .retry_count  (retry_count),
      .sup_state    (sup_state)
   );

   always @(negedge refclk) begin
      if (rst_n === 1'b1 && lock_lost === 1'b1) ll_pulses++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, " sup_state"},   sup_state,   e.st);
      check({tag, " pll_rst"},     pll_rst,     e.prst);
      check({tag, " core_rst_n"},  core_rst_n,  e.core);
      check({tag, " lock_lost"},   lock_lost,   e.ll);
      check({tag, " retry_count"}, retry_count, e.retry);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge refclk);
   endtask

   function automatic void add(input logic l, input logic f, input int n, input logic [1:0] st,
                               input logic p, input logic c, input logic ll, input int r);
      vec_t v;
      v.locked = l; v.frc = f; v.n = n; v.st = st;
      v.prst = p; v.core = c; v.ll = ll; v.retry = r;
      tbl.push_back(v);
   endfunction

   initial begin
      exp_t e;
      int   exp_r;

      // Cycle numbers in the notes are counted from the rst_n release (cycle 0).
      //  locked frc  n  st prst core ll retry
      add(0, 0, 3,  0, 1, 0, 0, 0);   // c3  PLL_RESET hold
      add(0, 0, 1,  1, 0, 0, 0, 0);   // c4  WAIT_LOCK after 4 cycles
      add(0, 0, 2,  1, 0, 0, 0, 0);   // c6
      add(1, 0, 2,  1, 0, 0, 0, 0);   // c8  lock seen through synchronizer
      add(1, 0, 1,  2, 0, 0, 0, 0);   // c9  STABLE_WAIT
      add(1, 0, 7,  2, 0, 0, 0, 0);   // c16
      add(1, 0, 1,  3, 0, 0, 0, 0);   // c17 RUN
      add(1, 0, 1,  3, 0, 1, 0, 0);   // c18 core released
      add(0, 0, 2,  3, 0, 1, 0, 0);   // c20 drop not yet acted on
      add(0, 0, 1,  0, 1, 1, 1, 1);   // c21 lock_lost pulse
      add(0, 0, 1,  0, 1, 0, 0, 1);   // c22
      add(0, 0, 2,  0, 1, 0, 0, 1);   // c24
      add(0, 0, 1,  1, 0, 0, 0, 1);   // c25 pll_rst was high 4 cycles
      add(1, 0, 3,  2, 0, 0, 0, 1);   // c28 STABLE_WAIT
      add(1, 0, 2,  2, 0, 0, 0, 1);   // c30
      add(0, 0, 1,  2, 0, 0, 0, 1);   // c31 one-cycle glitch in flight
      add(1, 0, 2,  1, 0, 0, 0, 1);   // c33 back to WAIT_LOCK, no retry
      add(1, 0, 1,  2, 0, 0, 0, 1);   // c34 counter restarted
      add(1, 0, 7,  2, 0, 0, 0, 1);   // c41
      add(1, 0, 1,  3, 0, 0, 0, 1);   // c42 RUN
      add(1, 0, 1,  3, 0, 1, 0, 1);   // c43
      add(0, 0, 2,  3, 0, 1, 0, 1);   // c45 locked_s low now
      add(0, 1, 1,  0, 1, 1, 0, 2);   // c46 force wins, no lock_lost
      add(0, 0, 1,  0, 1, 0, 0, 2);   // c47
      add(0, 0, 3,  1, 0, 0, 0, 2);   // c50
      add(0, 0, 31, 1, 0, 0, 0, 2);   // c81 last WAIT_LOCK cycle
      add(0, 0, 1,  0, 1, 0, 0, 3);   // c82 timeout retry
      add(0, 0, 4,  1, 0, 0, 0, 3);   // c86
      add(0, 1, 1,  0, 1, 0, 0, 4);   // c87 force from WAIT_LOCK
      add(0, 1, 3,  0, 1, 0, 0, 4);   // c90 held force does not extend
      add(0, 1, 1,  1, 0, 0, 0, 4);   // c91
      add(0, 1, 1,  0, 1, 0, 0, 5);   // c92 re-entered while held
      add(0, 0, 4,  1, 0, 0, 0, 5);   // c96

      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      force_relock = 1'b0;
      cycles(2);
      e.st = 2'd0; e.prst = 1'b1; e.core = 1'b0; e.ll = 1'b0; e.retry = 0;
      check_all("reset", e);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         pll_locked   = tbl[i].locked;
         force_relock = tbl[i].frc;
         e.st = tbl[i].st; e.prst = tbl[i].prst; e.core = tbl[i].core;
         e.ll = tbl[i].ll; e.retry = tbl[i].retry;
         sb.push_back(e);
         cycles(tbl[i].n);
         e = sb.pop_front();
         check_all($sformatf("v%0d", i), e);
      end

      // Asynchronous reset while in STABLE_WAIT.
      pll_locked = 1'b1;
      cycles(3);
      check("pre_rst sup_state", sup_state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      e.st = 2'd0; e.prst = 1'b1; e.core = 1'b0; e.ll = 1'b0; e.retry = 0;
      check_all("async_rst", e);
      @(negedge refclk);
      rst_n = 1'b1;
      cycles(3);
      check("rehold sup_state", sup_state, 0);
      check("rehold pll_rst", pll_rst, 1);
      cycles(1);
      check("rehold_end sup_state", sup_state, 1);
      check("rehold_end pll_rst", pll_rst, 0);

      // Never locks: retry every 4+32 cycles, saturating at 255.
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         cycles(35);
         if (k <= 3 || k == 300) check($sformatf("sat%0d wait", k), sup_state, 1);
         cycles(1);
         exp_r = (k > 255) ? 255 : k;
         if (k <= 3 || k == 255 || k == 256 || k == 300) begin
            check($sformatf("sat%0d sup_state", k), sup_state, 0);
            check($sformatf("sat%0d retry_count", k), retry_count, exp_r);
         end
      end

      check("lock_lost pulse total", ll_pulses, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
